// File: rtl/spdif_tx_sample_scheduler.sv
// SPDIF/AES3 transmitter sample scheduler: show-ahead sample FIFO, prefill/run/stop sequencing,
// underrun muting with re-prime, and frame index tracking within the 192-frame audio block.
module spdif_tx_sample_scheduler #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned START_LEVEL  = 4,
    parameter int unsigned MAX_UNDERRUN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [2*SAMPLE_WIDTH-1:0]     s_data_i,
    output logic                          tx_rst_n_o,
    output logic                          tx_halt_o,
    input  logic                          tx_ready_i,
    output logic [2*SAMPLE_WIDTH-1:0]     tx_sample_o,
    output logic [$clog2(DEPTH):0]        fill_level_o,
    output logic [7:0]                    frame_idx_o,
    output logic                          underrun_o,
    output logic [15:0]                   underrun_cnt_o,
    output logic                          busy_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(MAX_UNDERRUN + 1);
    localparam int unsigned DW = 2 * SAMPLE_WIDTH;

    if (!(SAMPLE_WIDTH == 16 || SAMPLE_WIDTH == 20 || SAMPLE_WIDTH == 24)) begin : g_bad_width
        $error("SAMPLE_WIDTH must be 16, 20 or 24");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end
    if (START_LEVEL < 1 || START_LEVEL > DEPTH) begin : g_bad_start
        $error("START_LEVEL must be in 1..DEPTH");
    end
    if (MAX_UNDERRUN < 1) begin : g_bad_underrun
        $error("MAX_UNDERRUN must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN,
        S_STOPPING
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DW-1:0]     r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [CW-1:0]     r_consec;
    logic [7:0]        r_frame_idx;
    logic [15:0]       r_underrun_cnt;
    logic              r_tx_rst_n;
    logic              r_tx_halt;

    logic [AW:0]       w_level;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_active;
    logic              w_run_strobe;
    logic              w_pop;
    logic              w_mute;
    logic              w_reprime;

    assign w_level      = r_wr_ptr - r_rd_ptr;
    assign w_empty      = (w_level == '0);
    assign w_full       = (w_level == LW'(DEPTH));
    assign w_push       = s_valid_i && !w_full;
    assign w_active     = (r_state == S_RUN) || (r_state == S_STOPPING);
    assign w_run_strobe = (r_state == S_RUN) && tx_ready_i;
    assign w_pop        = w_run_strobe && !w_empty;
    assign w_mute       = w_run_strobe && w_empty;
    assign w_reprime    = w_mute && (r_consec == CW'(MAX_UNDERRUN - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (enable_i) w_next = S_PREFILL;
            S_PREFILL: begin
                if (!enable_i)                          w_next = S_IDLE;
                else if (w_level >= LW'(START_LEVEL))   w_next = S_RUN;
            end
            S_RUN: begin
                if (!enable_i)      w_next = S_STOPPING;
                else if (w_reprime) w_next = S_PREFILL;
            end
            S_STOPPING: if (tx_ready_i) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Sample storage carries no reset; the mute path hides stale entries while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_consec       <= '0;
            r_frame_idx    <= '0;
            r_underrun_cnt <= '0;
            r_tx_rst_n     <= 1'b0;
            r_tx_halt      <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            // RUN entry looks ahead so the transmitter is live in the first RUN cycle;
            // every other transition lags the state register by one cycle.
            r_tx_rst_n <= (w_next == S_RUN) || w_active;
            r_tx_halt  <= !((w_next == S_RUN) || w_active);

            // The final STOPPING strobe completes its frame (index advances) without popping.
            if (r_state == S_PREFILL && w_next == S_RUN)
                r_frame_idx <= '0;
            else if (w_active && tx_ready_i)
                r_frame_idx <= (r_frame_idx == 8'd191) ? 8'd0 : r_frame_idx + 8'd1;

            if (w_mute && r_underrun_cnt != 16'hFFFF)
                r_underrun_cnt <= r_underrun_cnt + 16'd1;

            if (w_next == S_IDLE || w_next == S_PREFILL) r_consec <= '0;
            else if (w_pop)                              r_consec <= '0;
            else if (w_mute)                             r_consec <= r_consec + 1'b1;
        end
    end

    assign s_ready_o      = !w_full;
    assign tx_sample_o    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fill_level_o   = w_level;
    assign frame_idx_o    = r_frame_idx;
    assign underrun_o     = w_mute;
    assign underrun_cnt_o = r_underrun_cnt;
    assign busy_o         = w_active;
    assign tx_rst_n_o     = r_tx_rst_n;
    assign tx_halt_o      = r_tx_halt;

endmodule

// File: tb/tb_spdif_tx_sample_scheduler.sv
// Randomised and directed bench for spdif_tx_sample_scheduler against a queue-based frame model.
module tb_spdif_tx_sample_scheduler;

    localparam int SW    = 16;
    localparam int DEPTH = 8;
    localparam int START = 4;
    localparam int MAXU  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [31:0]   s_data_i;
    logic          tx_rst_n_o;
    logic          tx_halt_o;
    logic          tx_ready_i;
    logic [31:0]   tx_sample_o;
    logic [3:0]    fill_level_o;
    logic [7:0]    frame_idx_o;
    logic          underrun_o;
    logic [15:0]   underrun_cnt_o;
    logic          busy_o;

    always #5 clk = ~clk;

    spdif_tx_sample_scheduler #(
        .SAMPLE_WIDTH (SW),
        .DEPTH        (DEPTH),
        .START_LEVEL  (START),
        .MAX_UNDERRUN (MAXU)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .s_data_i       (s_data_i),
        .tx_rst_n_o     (tx_rst_n_o),
        .tx_halt_o      (tx_halt_o),
        .tx_ready_i     (tx_ready_i),
        .tx_sample_o    (tx_sample_o),
        .fill_level_o   (fill_level_o),
        .frame_idx_o    (frame_idx_o),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt_o),
        .busy_o         (busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: mode 0 idle, 1 prefill, 2 run, 3 stopping.
    logic [31:0] mq[$];
    int          md = 0;
    int          mframe = 0;
    int          mcnt = 0;
    int          mcons = 0;
    bit          mtxr = 1'b0;
    logic [31:0] last_data;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endfunction

    task automatic compare_all();
        bit emp;
        emp = (mq.size() == 0);
        chk("s_ready",      64'(s_ready_o),      64'(mq.size() < DEPTH));
        chk("fill_level",   64'(fill_level_o),   64'(mq.size()));
        chk("tx_sample",    64'(tx_sample_o),    emp ? 64'd0 : 64'(mq[0]));
        chk("tx_rst_n",     64'(tx_rst_n_o),     64'(mtxr));
        chk("tx_halt",      64'(tx_halt_o),      64'(!mtxr));
        chk("frame_idx",    64'(frame_idx_o),    64'(mframe));
        chk("underrun",     64'(underrun_o),     64'(md == 2 && tx_ready_i && emp));
        chk("underrun_cnt", 64'(underrun_cnt_o), 64'(mcnt));
        chk("busy",         64'(busy_o),         64'(md >= 2));
    endtask

    task automatic step_model();
        int  sz;
        bit  emp;
        bit  act;
        int  nm;
        sz  = mq.size();
        emp = (sz == 0);
        act = (md >= 2);
        if (!rst_n) begin
            mq.delete();
            md = 0; mframe = 0; mcnt = 0; mcons = 0; mtxr = 1'b0;
            return;
        end
        nm = md;
        case (md)
            0: if (enable_i) nm = 1;
            1: if (!enable_i) nm = 0; else if (sz >= START) nm = 2;
            2: if (!enable_i) nm = 3; else if (tx_ready_i && emp && mcons + 1 >= MAXU) nm = 1;
            default: if (tx_ready_i) nm = 0;
        endcase
        if (md == 2 && tx_ready_i) begin
            if (!emp) begin
                void'(mq.pop_front());
                mcons = 0;
            end else begin
                if (mcnt < 65535) mcnt++;
                mcons++;
            end
        end
        if (act && tx_ready_i) mframe = (mframe + 1) % 192;
        if (s_valid_i && sz < DEPTH) mq.push_back(s_data_i);
        if (nm == 2 && md != 2) mframe = 0;
        mtxr = (nm == 2) || act;
        if (nm < 2) mcons = 0;
        md = nm;
    endtask

    // Called at posedge+1: inputs applied, compared mid-cycle, model advanced on the edge.
    task automatic drv(input bit e, input bit v, input bit r, input bit rs = 1'b1);
        enable_i   = e;
        s_valid_i  = v;
        tx_ready_i = r;
        rst_n      = rs;
        s_data_i   = $urandom;
        last_data  = s_data_i;
        #3;
        compare_all();
        @(posedge clk);
        step_model();
        cyc++;
        #1;
    endtask

    logic [31:0] first_sample;
    int          wraps;
    logic [7:0]  prev_idx;

    initial begin
        rst_n = 1'b0; enable_i = 1'b0; s_valid_i = 1'b0; tx_ready_i = 1'b0; s_data_i = '0;
        @(posedge clk);
        step_model();
        #1;
        drv(0, 0, 0, 0);
        chk("rst_fill",    64'(fill_level_o), 64'd0);
        chk("rst_txrst",   64'(tx_rst_n_o),   64'd0);
        chk("rst_halt",    64'(tx_halt_o),    64'd1);
        chk("rst_sready",  64'(s_ready_o),    64'd1);
        chk("rst_busy",    64'(busy_o),       64'd0);
        chk("rst_sample",  64'(tx_sample_o),  64'd0);

        // Prefill: three samples keep the transmitter in reset, the fourth starts RUN.
        drv(1, 1, 0);
        first_sample = last_data;
        drv(1, 1, 0);
        drv(1, 1, 0);
        drv(1, 0, 0);
        drv(1, 0, 0);
        chk("pre3_fill",  64'(fill_level_o), 64'd3);
        chk("pre3_txrst", 64'(tx_rst_n_o),   64'd0);
        drv(1, 1, 0);
        drv(1, 0, 0);
        chk("run1_txrst",  64'(tx_rst_n_o),  64'd1);
        chk("run1_frame",  64'(frame_idx_o), 64'd0);
        chk("run1_sample", 64'(tx_sample_o), 64'(first_sample));
        drv(1, 0, 1);
        chk("run1_frame_after", 64'(frame_idx_o), 64'd1);

        // Steady stream at frame rate: 400 frames, two block wraps.
        wraps = 0;
        for (int i = 0; i < 400; i++) begin
            drv(1, 1, 0);
            drv(1, 0, 0);
            prev_idx = frame_idx_o;
            drv(1, 0, 1);
            if (prev_idx == 8'd191 && frame_idx_o == 8'd0) wraps++;
            drv(1, 0, 0);
        end
        chk("stream_wraps",    64'(wraps),          64'd2);
        chk("stream_frame",    64'(frame_idx_o),    64'd17);
        chk("stream_underrun", 64'(underrun_cnt_o), 64'd0);

        // Underrun: three remaining samples drain, then four muted frames force a re-prime.
        for (int i = 0; i < 7; i++) begin
            drv(1, 0, 0);
            drv(1, 0, 1);
        end
        chk("ur_cnt",    64'(underrun_cnt_o), 64'd4);
        chk("ur_busy",   64'(busy_o),         64'd0);
        chk("ur_txrst1", 64'(tx_rst_n_o),     64'd1);
        drv(1, 0, 0);
        chk("ur_txrst2", 64'(tx_rst_n_o),     64'd0);

        // Full FIFO while idle, then push+pop at level 7.
        drv(0, 0, 0);
        for (int i = 0; i < 10; i++) drv(0, 1, 0);
        chk("full_fill",   64'(fill_level_o), 64'd8);
        chk("full_sready", 64'(s_ready_o),    64'd0);
        drv(1, 0, 0);
        drv(1, 0, 0);
        drv(1, 0, 1);
        drv(1, 1, 1);
        chk("pushpop_fill", 64'(fill_level_o), 64'd7);

        // Stop mid-frame: no pop on the completing strobe.
        drv(0, 0, 0);
        drv(1, 0, 0);
        drv(1, 0, 0);
        chk("stop_busy", 64'(busy_o),       64'd1);
        drv(0, 0, 1);
        chk("stop_fill",  64'(fill_level_o), 64'd7);
        chk("stop_idle",  64'(busy_o),       64'd0);
        drv(0, 0, 0);
        chk("stop_txrst", 64'(tx_rst_n_o),   64'd0);

        // Reset mid-run.
        drv(1, 0, 0);
        drv(1, 0, 0);
        drv(1, 1, 1);
        drv(1, 1, 1);
        drv(1, 0, 0, 0);
        chk("mrst_fill",  64'(fill_level_o), 64'd0);
        chk("mrst_busy",  64'(busy_o),       64'd0);
        chk("mrst_txrst", 64'(tx_rst_n_o),   64'd0);

        // Random traffic, including stops, underruns and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            drv(($urandom % 16) != 0, $urandom % 2, ($urandom % 4) == 0, ($urandom % 500) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
